// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature up/down decoder.
//   QUAD_Sxx  : {A,B} encodings of the four quadrature states.
//   quad_evt_t: classification of one prev->cur transition.
//   quad_dir  : classifies a transition as a legal step (with direction), illegal, or no event.
package quad_pkg;

    localparam logic [1:0] QUAD_S00 = 2'b00;
    localparam logic [1:0] QUAD_S10 = 2'b10;
    localparam logic [1:0] QUAD_S11 = 2'b11;
    localparam logic [1:0] QUAD_S01 = 2'b01;

    typedef struct packed {
        logic valid;    // legal single-bit Gray step
        logic up;       // direction of the step (1 = A leads)
        logic illegal;  // both channels changed at once
    } quad_evt_t;

    function automatic quad_evt_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
        quad_evt_t evt;
        evt = '0;
        case ({prev, cur})
            {QUAD_S00, QUAD_S10},
            {QUAD_S10, QUAD_S11},
            {QUAD_S11, QUAD_S01},
            {QUAD_S01, QUAD_S00}: begin
                evt.valid = 1'b1;
                evt.up    = 1'b1;
            end
            {QUAD_S00, QUAD_S01},
            {QUAD_S01, QUAD_S11},
            {QUAD_S11, QUAD_S10},
            {QUAD_S10, QUAD_S00}: begin
                evt.valid = 1'b1;
                evt.up    = 1'b0;
            end
            {QUAD_S00, QUAD_S11},
            {QUAD_S11, QUAD_S00},
            {QUAD_S10, QUAD_S01},
            {QUAD_S01, QUAD_S10}: begin
                evt.illegal = 1'b1;
            end
            default: evt = '0;
        endcase
        return evt;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser followed by a level-acceptance glitch filter for one
// quadrature channel. A new synchronised level is accepted only after it has
// differed from the current filtered level for FILTER_CYCLES consecutive cycles.
//   clk      : system clock (rising edge)
//   rst      : asynchronous active-high reset
//   raw      : asynchronous input pin
//   filtered : synchronised, de-glitched level
module quad_input_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filtered
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(FILTER_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            filtered <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != filtered) begin
                // Accept on the FILTER_CYCLES-th consecutive cycle of disagreement.
                if (cnt == TC) begin
                    filtered <= sync2;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_updown_decoder.sv
// Quadrature (A/B) decoder with position counter. Each pin is synchronised and
// glitch-filtered, Gray transitions are decoded against the previous filtered
// state, legal steps move the count up or down, and double-bit jumps are flagged.
//   i_clk        : system clock (rising edge)
//   i_rst        : asynchronous active-high reset
//   i_a, i_b     : quadrature pins, asynchronous to i_clk
//   i_clr        : synchronous clear of o_count and o_err_sticky
//   o_step       : one-cycle pulse per legal transition
//   o_dir        : direction of the last legal step (1 = up)
//   o_count      : position, modulo 2^WIDTH
//   o_wrap       : one-cycle pulse when the count wraps in either direction
//   o_err        : one-cycle pulse on an illegal transition
//   o_err_sticky : latched error, cleared by i_clr or i_rst
module quad_updown_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_clr,
    output logic             o_step,
    output logic             o_dir,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap,
    output logic             o_err,
    output logic             o_err_sticky
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic      a_filt;
    logic      b_filt;
    logic [1:0] cur;
    logic [1:0] prev;
    quad_evt_t evt;

    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
        .clk      (i_clk),
        .rst      (i_rst),
        .raw      (i_a),
        .filtered (a_filt)
    );

    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk      (i_clk),
        .rst      (i_rst),
        .raw      (i_b),
        .filtered (b_filt)
    );

    assign cur = {a_filt, b_filt};
    assign evt = quad_dir(prev, cur);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev         <= QUAD_S00;
            o_step       <= 1'b0;
            o_dir        <= 1'b0;
            o_count      <= '0;
            o_wrap       <= 1'b0;
            o_err        <= 1'b0;
            o_err_sticky <= 1'b0;
        end else begin
            prev   <= cur;
            o_step <= 1'b0;
            o_wrap <= 1'b0;
            o_err  <= 1'b0;

            if (evt.valid) begin
                o_step <= 1'b1;
                o_dir  <= evt.up;
                if (evt.up) begin
                    o_count <= o_count + CNT_ONE;
                    o_wrap  <= (o_count == CNT_MAX);
                end else begin
                    o_count <= o_count - CNT_ONE;
                    o_wrap  <= (o_count == '0);
                end
            end

            if (evt.illegal) begin
                o_err        <= 1'b1;
                o_err_sticky <= 1'b1;
            end

            // Clear wins over a coincident step or error; step/dir/err pulses
            // still report what happened on the pins.
            if (i_clr) begin
                o_count      <= '0;
                o_wrap       <= 1'b0;
                o_err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Directed bench for quad_updown_decoder (WIDTH=8, FILTER_CYCLES=4).
module tb_quad_updown_decoder;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       clr;
    logic       step;
    logic       dir;
    logic [7:0] count;
    logic       wrap;
    logic       err;
    logic       err_sticky;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int step_seen = 0;
    int wrap_seen = 0;
    int err_seen  = 0;

    quad_updown_decoder #(.WIDTH(8), .FILTER_CYCLES(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_a          (a),
        .i_b          (b),
        .i_clr        (clr),
        .o_step       (step),
        .o_dir        (dir),
        .o_count      (count),
        .o_wrap       (wrap),
        .o_err        (err),
        .o_err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle; a pulse stuck high counts more than once.
    always @(negedge clk) begin
        if (step) step_seen++;
        if (wrap) wrap_seen++;
        if (err)  err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic va, input logic vb, input int hold);
        a = va;
        b = vb;
        tick(hold);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    logic [1:0] up_seq [4];
    int         e0;
    int         s0;

    initial begin
        up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        clr = 1'b0;
        tick(3);
        check("rst_count", count, 0);
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_sticky", err_sticky, 0);

        // Idle after reset: no events.
        rst = 1'b0;
        tick(50);
        check("idle_steps", step_seen, 0);
        check("idle_errs", err_seen, 0);
        check("idle_count", count, 0);
        check("idle_sticky", err_sticky, 0);

        // First up transition with exact latency: step registered at edge 6.
        a = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("latency_edge%0d", e), step, (e == 6) ? 1 : 0);
        end
        tick(2);
        for (int i = 1; i < 16; i++)
            drive(up_seq[i % 4][1], up_seq[i % 4][0], 10);
        check("up_steps", step_seen, 16);
        check("up_dir", dir, 1);
        check("up_count", count, 16);
        check("up_nowrap", wrap_seen, 0);

        pulse_clr();
        check("clr_count", count, 0);

        // Down wrap 0 -> 255, then back up 255 -> 0.
        drive(1'b0, 1'b1, 10);
        check("down_count", count, 8'hFF);
        check("down_wrap", wrap_seen, 1);
        check("down_dir", dir, 0);
        drive(1'b0, 1'b0, 10);
        check("upwrap_count", count, 0);
        check("upwrap_wrap", wrap_seen, 2);
        check("upwrap_dir", dir, 1);

        // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted.
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 10);
        check("glitch3_steps", step_seen, 18);
        check("glitch3_count", count, 0);
        drive(1'b1, 1'b0, 4);
        drive(1'b0, 1'b0, 10);
        check("glitch4_steps", step_seen, 20);
        check("glitch4_count", count, 0);
        check("glitch4_dir", dir, 0);

        // Illegal 00 -> 11.
        drive(1'b1, 1'b1, 10);
        check("err_pulses", err_seen, 1);
        check("err_sticky", err_sticky, 1);
        check("err_count", count, 0);
        check("err_dir", dir, 0);
        check("err_nostep", step_seen, 20);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        check("after_err_count", count, 8'hFE);
        check("sticky_holds", err_sticky, 1);
        pulse_clr();
        check("clr2_count", count, 0);
        check("clr2_sticky", err_sticky, 0);

        // Count up to 5, ending at AB=10.
        for (int i = 0; i < 5; i++)
            drive(up_seq[i % 4][1], up_seq[i % 4][0], 10);
        check("five_count", count, 5);

        // Clear coincident with the 10 -> 11 up step (registered at edge 6).
        b = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("coclr_count", count, 0);
        check("coclr_step", step, 1);
        check("coclr_wrap", wrap, 0);
        check("coclr_dir", dir, 1);
        clr = 1'b0;
        tick(4);

        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        check("pre_rst_count", count, 4);

        // Asynchronous reset mid-cycle while AB=11.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_dir", dir, 0);
        check("arst_step", step, 0);
        check("arst_sticky", err_sticky, 0);
        tick(2);
        e0 = err_seen;
        s0 = step_seen;
        rst = 1'b0;
        tick(12);
        check("post_rst_err", err_seen, e0 + 1);
        check("post_rst_sticky", err_sticky, 1);
        check("post_rst_count", count, 0);
        check("post_rst_nostep", step_seen, s0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/quad_updown_decoder.md
Name: quad_updown_decoder

Overview:
- Receive-side front end for the up/down counters: decodes a 2-channel quadrature signal (A/B, e.g. rotary encoder) into step/direction events and maintains a WIDTH-bit position count.
- Asynchronous A/B pins are synchronised and glitch-filtered, Gray transitions are decoded, illegal jumps are flagged, and each legal step updates the count (up or down).
- Sits between the external encoder pins and any logic that consumes position or step/direction.

Parameters:
- WIDTH, 8, position counter bit-width (>=2).
- FILTER_CYCLES, 4, consecutive cycles a synchronised input must hold a new level before it is accepted (>=1).

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_a  input  1  quadrature channel A, asynchronous to i_clk.
- i_b  input  1  quadrature channel B, asynchronous to i_clk.
- i_clr  input  1  synchronous clear of o_count and o_err_sticky.
- o_step  output  1  one-cycle pulse per legal quadrature transition.
- o_dir  output  1  direction of the last legal step (1 = up, 0 = down); holds between steps.
- o_count  output  WIDTH  position count, modulo 2^WIDTH.
- o_wrap  output  1  one-cycle pulse when o_count wraps (max->0 up, 0->max down).
- o_err  output  1  one-cycle pulse on an illegal transition (A and B both change).
- o_err_sticky  output  1  set by o_err, cleared only by i_clr or i_rst.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - All outputs, sync flops, filter counters, filtered AB and previous AB go to 0.
  - Filtered AB = previous AB = 00, so no step is generated on release.
- Synchroniser: 2 flops per channel (sync1, sync2).
- Filter, per channel, independent:
  - The counter increments while sync2 != filtered; it clears to 0 when they are equal.
  - When the counter = FILTER_CYCLES-1 and sync2 != filtered, filtered <= sync2 and the counter clears.
  - A glitch shorter than FILTER_CYCLES cycles never reaches the decoder.
- Latency: input change sampled at edge 0 -> sync2 at edge 1 -> filtered at edge 1+FILTER_CYCLES -> o_step/o_count/o_dir at edge 2+FILTER_CYCLES.
- Decode: compare filtered AB (cur) with registered previous AB (prev); prev <= cur every cycle.
  - Up sequence (A leads): 00->10->11->01->00. Each such transition gives o_step=1, o_dir=1, o_count+1.
  - Down sequence: 00->01->11->10->00. Each gives o_step=1, o_dir=0, o_count-1.
  - cur == prev: no event.
  - Both bits differ (00<->11, 10<->01): o_err=1 and o_err_sticky=1. No step; count and o_dir unchanged.
- Count arithmetic: modulo 2^WIDTH.
  - Up from 2^WIDTH-1 gives 0 with o_wrap=1.
  - Down from 0 gives 2^WIDTH-1 with o_wrap=1.
- i_clr:
  - Next edge: o_count=0, o_err_sticky=0.
  - Overrides a coincident step: the count goes to 0, not 0+-1, and o_wrap=0. o_step and o_dir still reflect the step.
  - A coincident o_err still pulses, but sticky ends at 0.
- Reset mid-operation: immediate return to the reset state. After release, the first filtered value that differs from 00 is decoded normally against prev=00; a first filtered value of 11 flags an error.
- Steps can be accepted at most once every FILTER_CYCLES cycles per channel. Faster input is undefined aliasing; it is not required to be detected.

Decomposition:
- Package quad_pkg:
  - localparams for the AB encodings (QUAD_S00, QUAD_S10, QUAD_S11, QUAD_S01).
  - Function quad_dir(prev,cur) returning {valid, up, illegal}.
- Sub-module quad_input_filter (sync + glitch filter, parameter FILTER_CYCLES), instantiated once per channel.
- Decode and count logic stays in the top module.

Test Plan:
- Reset, then hold A=B=0 for 50 cycles -> o_step never asserts, o_count=0, o_err_sticky=0.
- Four full up cycles, each level held 10 cycles (FILTER_CYCLES=4) -> 16 o_step pulses, o_dir=1, o_count=16. Each pulse falls exactly 6 edges after the sampling edge of the A/B change.
- From o_count=0, one down transition 00->01 -> o_count=255, o_wrap pulse, o_dir=0. Then 01->00 -> o_count=0, o_wrap pulse.
- 3-cycle pulse on A while B is stable -> no step, count unchanged. A 4-cycle pulse -> one up step, then one down step.
- Force AB 00->11 simultaneously -> o_err one-cycle pulse, o_err_sticky=1, count unchanged. Assert i_clr -> sticky 0 and count 0.
- i_clr coincident with an up step at o_count=5 -> o_count=0, o_step=1, o_wrap=0. Then assert i_rst mid-sequence at AB=11 -> all outputs 0 asynchronously; after release one error is flagged.
